// File: rtl/quadrature_decoder_if.sv
// Quadrature encoder channels, decode enable and the step/direction/count results.
// master drives the encoder side; slave is the decoder.
interface quadrature_decoder_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic             qa;
    logic             qb;
    logic             step;
    logic             up_down;
    logic [WIDTH-1:0] count;
    logic             error;

    modport master (
        output enable, qa, qb,
        input  step, up_down, count, error
    );

    modport slave (
        input  enable, qa, qb,
        output step, up_down, count, error
    );
endinterface

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: synchronizes qa/qb, decodes Gray transitions into step/up_down/count and flags illegal jumps.
// Latency: SYNC_STAGES cycles from input change to registered step/error/count; no backpressure (free-running).
module quadrature_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic                clk,
    input logic                reset,
    quadrature_decoder_if.slave qd
);
    typedef enum logic {INIT, RUN} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_ILLEGAL} dir_t;

    state_t           state_q, state_nxt;
    logic [2:0]       init_cnt_q, init_cnt_nxt;
    logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q;
    logic [1:0]       s, prev_q;
    dir_t             dir;

    logic             step_q, step_nxt;
    logic             error_q, error_nxt;
    logic             up_down_q, up_down_nxt;
    logic [WIDTH-1:0] count_q, count_nxt;

    assign s = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a_q <= '0;
            sync_b_q <= '0;
            prev_q   <= 2'b00;
        end else begin
            sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], qd.qa};
            sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], qd.qb};
            // prev follows s unconditionally so moves seen while disabled are absorbed
            prev_q   <= s;
        end
    end

    // Gray sequence 00 -> 01 -> 11 -> 10 -> 00 counts up
    always_comb begin
        dir = DIR_NONE;
        case ({prev_q, s})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: dir = DIR_UP;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: dir = DIR_DOWN;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: dir = DIR_ILLEGAL;
            default:                                dir = DIR_NONE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            step_q     <= 1'b0;
            error_q    <= 1'b0;
            up_down_q  <= 1'b1;
            count_q    <= '0;
        end else begin
            state_q    <= state_nxt;
            init_cnt_q <= init_cnt_nxt;
            step_q     <= step_nxt;
            error_q    <= error_nxt;
            up_down_q  <= up_down_nxt;
            count_q    <= count_nxt;
        end
    end

    // INIT waits until the synchronizer and prev hold real samples before decoding
    always_comb begin
        state_nxt    = state_q;
        init_cnt_nxt = init_cnt_q;
        step_nxt     = 1'b0;
        error_nxt    = 1'b0;
        up_down_nxt  = up_down_q;
        count_nxt    = count_q;
        case (state_q)
            INIT: begin
                if (init_cnt_q == 3'(SYNC_STAGES)) begin
                    state_nxt = RUN;
                end else begin
                    init_cnt_nxt = init_cnt_q + 3'd1;
                end
            end
            RUN: begin
                if (qd.enable) begin
                    case (dir)
                        DIR_UP: begin
                            step_nxt    = 1'b1;
                            up_down_nxt = 1'b1;
                            count_nxt   = count_q + 1'b1;
                        end
                        DIR_DOWN: begin
                            step_nxt    = 1'b1;
                            up_down_nxt = 1'b0;
                            count_nxt   = count_q - 1'b1;
                        end
                        DIR_ILLEGAL: error_nxt = 1'b1;
                        default: ;
                    endcase
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    assign qd.step    = step_q;
    assign qd.error   = error_q;
    assign qd.up_down = up_down_q;
    assign qd.count   = count_q;
endmodule

// File: tb/tb_quadrature_decoder.sv
// Randomized and directed bench for quadrature_decoder against a Gray-position reference model.
module tb_quadrature_decoder;
    localparam int WIDTH = 4;
    localparam int SYNC  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;

    quadrature_decoder_if #(.WIDTH(WIDTH)) qd ();

    quadrature_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
        .clk   (clk),
        .reset (reset),
        .qd    (qd.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [1:0] hist[$];
    int         n;
    int         m_count;
    logic       m_ud;
    logic       m_step;
    logic       m_err;
    int         p_step;
    int         p_err;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", tag, got, exp, n, $time);
        end
    endtask

    // position of a Gray code along the UP direction
    function automatic int gray_pos(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] h(input int k);
        if (k < 1) return 2'b00;
        return hist[k-1];
    endfunction

    task automatic model_reset();
        hist.delete();
        n       = 0;
        m_count = 0;
        m_ud    = 1'b1;
        m_step  = 1'b0;
        m_err   = 1'b0;
    endtask

    // Advance one edge: the decode at edge n compares inputs seen at edges n-SYNC-1 and n-SYNC
    task automatic tick();
        int d;
        @(posedge clk);
        n++;
        hist.push_back({qd.qa, qd.qb});
        m_step = 1'b0;
        m_err  = 1'b0;
        if (n >= SYNC + 2 && qd.enable) begin
            d = (gray_pos(h(n - SYNC)) - gray_pos(h(n - SYNC - 1)) + 4) % 4;
            if (d == 1) begin
                m_step = 1'b1; m_ud = 1'b1; m_count = (m_count + 1) % (1 << WIDTH);
            end else if (d == 3) begin
                m_step = 1'b1; m_ud = 1'b0; m_count = (m_count + (1 << WIDTH) - 1) % (1 << WIDTH);
            end else if (d == 2) begin
                m_err = 1'b1;
            end
        end
        #1;
        check_val("step", int'(qd.step), int'(m_step));
        check_val("error", int'(qd.error), int'(m_err));
        check_val("count", int'(qd.count), m_count);
        check_val("up_down", int'(qd.up_down), int'(m_ud));
        if (qd.step && qd.error) check_val("step_err_excl", 1, 0);
        if (qd.step === 1'b1) p_step++;
        if (qd.error === 1'b1) p_err++;
    endtask

    task automatic hold(input logic [1:0] v, input int cycles);
        qd.qa = v[1];
        qd.qb = v[0];
        repeat (cycles) tick();
    endtask

    task automatic do_reset(input logic [1:0] v);
        qd.qa = v[1];
        qd.qb = v[0];
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check_val("rst_count", int'(qd.count), 0);
        check_val("rst_up_down", int'(qd.up_down), 1);
        check_val("rst_step", int'(qd.step), 0);
        check_val("rst_error", int'(qd.error), 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [1:0] cur;
        qd.qa = 1'b0;
        qd.qb = 1'b0;
        qd.enable = 1'b1;
        p_step = 0;
        p_err = 0;
        model_reset();

        // forward rotation from 00
        do_reset(2'b00);
        hold(2'b00, 10);
        p_step = 0; p_err = 0;
        hold(2'b00, 10); hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 10);
        check_val("fwd_steps", p_step, 4);
        check_val("fwd_errs", p_err, 0);
        check_val("fwd_count", int'(qd.count), 4);
        check_val("fwd_ud", int'(qd.up_down), 1);

        // reverse rotation wrapping through zero
        p_step = 0; p_err = 0;
        hold(2'b00, 10); hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10); hold(2'b00, 10); hold(2'b10, 10);
        check_val("rev_steps", p_step, 5);
        check_val("rev_count", int'(qd.count), 15);
        check_val("rev_ud", int'(qd.up_down), 0);

        // 10 -> 00 is UP (wraps to 0), then both channels flip together
        hold(2'b00, 10);
        p_step = 0; p_err = 0;
        hold(2'b11, 10);
        check_val("ill_errs", p_err, 1);
        check_val("ill_steps", p_step, 0);
        check_val("ill_count", int'(qd.count), 0);
        check_val("ill_ud", int'(qd.up_down), 1);

        // moves while disabled are absorbed
        p_step = 0; p_err = 0;
        qd.enable = 1'b0;
        hold(2'b10, 10); hold(2'b00, 10);
        qd.enable = 1'b1;
        hold(2'b00, 10);
        check_val("dis_steps", p_step, 0);
        check_val("dis_count", int'(qd.count), 0);
        hold(2'b01, 10);
        check_val("reen_steps", p_step, 1);
        check_val("reen_count", int'(qd.count), 1);

        // random walk: single-channel moves, occasional double flips, fast rates, enable toggles
        cur = 2'b01;
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 15);
            if (r == 0)      cur = ~cur;
            else if (r < 8)  cur[0] = ~cur[0];
            else             cur[1] = ~cur[1];
            qd.enable = ($urandom_range(0, 7) != 0);
            hold(cur, $urandom_range(1, 6));
        end
        qd.enable = 1'b1;
        hold(cur, 5);

        // 11 held through reset release must not step or error
        do_reset(2'b11);
        p_step = 0; p_err = 0;
        hold(2'b11, 10);
        check_val("init11_steps", p_step, 0);
        check_val("init11_errs", p_err, 0);

        // reach count 7 with up_down = 0, then reset without a clock edge
        hold(2'b10, 4); hold(2'b00, 4); hold(2'b01, 4); hold(2'b11, 4);
        hold(2'b10, 4); hold(2'b00, 4); hold(2'b01, 4); hold(2'b11, 4);
        hold(2'b01, 4);
        check_val("pre_rst_count", int'(qd.count), 7);
        check_val("pre_rst_ud", int'(qd.up_down), 0);
        do_reset(2'b01);
        hold(2'b01, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
